// File: rtl/dram_pattern_tester.sv
// dram_pattern_tester: Wishbone master that sweeps a DRAM word range twice.
// Phase 0 writes and reads back an address-derived pattern P(a); phase 1 does
// the same with ~P(a). Mismatches and bus errors are counted (saturating), the
// first failing address is latched, and pass/fail/timeout flags are reported.
//
// Ports:
//   user_clk, user_rst        clock, synchronous active-high reset
//   start                     begin a test (sampled in IDLE only)
//   init_done, init_error     litedram calibration status
//   wb_adr/wb_dat_w/wb_sel/wb_cyc/wb_stb/wb_we   wishbone master outputs
//   wb_dat_r/wb_ack/wb_err    wishbone slave responses
//   busy, done, pass, fail, timeout             test status
//   error_count, first_err_addr                 error reporting
module dram_pattern_tester #(
  parameter int unsigned ADDR_WIDTH     = 25,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned START_ADDR     = 0,
  parameter int unsigned NUM_WORDS      = 1024,
  parameter logic [31:0] SEED           = 32'h5EED_0000,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned ERR_CNT_WIDTH  = 16
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  input  logic                     start,
  input  logic                     init_done,
  input  logic                     init_error,
  output logic [ADDR_WIDTH-1:0]    wb_adr,
  output logic [DATA_WIDTH-1:0]    wb_dat_w,
  input  logic [DATA_WIDTH-1:0]    wb_dat_r,
  output logic [SEL_WIDTH-1:0]     wb_sel,
  output logic                     wb_cyc,
  output logic                     wb_stb,
  output logic                     wb_we,
  input  logic                     wb_ack,
  input  logic                     wb_err,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr
);

  localparam int unsigned LANES = DATA_WIDTH / 32;
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  // Loaded with N-1 so that the transaction is abandoned after exactly N wait cycles.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_COMPARE, S_DONE
  } state_t;

  state_t                   r_state, state_nxt;
  logic                     r_phase, phase_nxt;
  logic [IDX_W-1:0]         r_index, index_nxt;
  logic [TMO_W-1:0]         r_tmo, tmo_nxt;
  logic [DATA_WIDTH-1:0]    r_rd_data, rd_data_nxt;
  logic                     r_rd_err, rd_err_nxt;
  logic                     r_abort, abort_nxt;
  logic [ADDR_WIDTH-1:0]    r_wb_adr, wb_adr_nxt;
  logic [DATA_WIDTH-1:0]    r_wb_dat_w, wb_dat_w_nxt;
  logic                     r_wb_we, wb_we_nxt;
  logic                     r_wb_cyc, wb_cyc_nxt;
  logic                     r_busy, busy_nxt;
  logic                     r_done, done_nxt;
  logic                     r_pass, pass_nxt;
  logic                     r_fail, fail_nxt;
  logic                     r_timeout, timeout_nxt;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt, err_cnt_nxt;
  logic [ADDR_WIDTH-1:0]    r_first_err, first_err_nxt;

  logic [ADDR_WIDTH-1:0]    w_req_adr;
  logic [DATA_WIDTH-1:0]    w_req_dat;
  logic                     w_last;
  logic                     w_bad;
  logic                     w_pass;
  logic [ERR_CNT_WIDTH-1:0] w_cnt_inc;

  // Address-derived pattern, lane i = a ^ SEED ^ (i * 0x01010101), inverted in phase 1.
  function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [ADDR_WIDTH-1:0] adr,
                                                      input logic inv);
    logic [DATA_WIDTH-1:0] res;
    logic [31:0]           lane;
    res = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane = 32'(adr) ^ SEED ^ (32'(i) * 32'h0101_0101);
      res[32*i +: 32] = inv ? ~lane : lane;
    end
    return res;
  endfunction

  assign w_req_adr = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(r_index);
  assign w_req_dat = f_pattern(w_req_adr, r_phase);
  assign w_last    = (r_index == LAST_IDX);
  assign w_bad     = r_rd_err || (r_rd_data != f_pattern(r_wb_adr, r_phase));
  assign w_pass    = (r_err_cnt == '0) && !r_timeout && !r_abort;
  assign w_cnt_inc = (r_err_cnt == {ERR_CNT_WIDTH{1'b1}}) ? r_err_cnt
                                                          : r_err_cnt + ERR_CNT_WIDTH'(1);

  // State register.
  always_ff @(posedge user_clk) begin
    if (user_rst) r_state <= S_IDLE;
    else          r_state <= state_nxt;
  end

  // Next-state and next-register logic.
  always_comb begin
    state_nxt     = r_state;
    phase_nxt     = r_phase;
    index_nxt     = r_index;
    tmo_nxt       = r_tmo;
    rd_data_nxt   = r_rd_data;
    rd_err_nxt    = r_rd_err;
    abort_nxt     = r_abort;
    wb_adr_nxt    = r_wb_adr;
    wb_dat_w_nxt  = r_wb_dat_w;
    wb_we_nxt     = r_wb_we;
    wb_cyc_nxt    = r_wb_cyc;
    busy_nxt      = r_busy;
    done_nxt      = r_done;
    pass_nxt      = r_pass;
    fail_nxt      = r_fail;
    timeout_nxt   = r_timeout;
    err_cnt_nxt   = r_err_cnt;
    first_err_nxt = r_first_err;

    case (r_state)
      S_IDLE: begin
        // Without calibration status the start request is dropped entirely.
        if (start && (init_done || init_error)) begin
          done_nxt      = 1'b0;
          pass_nxt      = 1'b0;
          fail_nxt      = 1'b0;
          timeout_nxt   = 1'b0;
          err_cnt_nxt   = '0;
          first_err_nxt = '0;
          busy_nxt      = 1'b1;
          phase_nxt     = 1'b0;
          index_nxt     = '0;
          abort_nxt     = init_error;
          state_nxt     = init_error ? S_DONE : S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        wb_adr_nxt   = w_req_adr;
        wb_dat_w_nxt = w_req_dat;
        wb_we_nxt    = 1'b1;
        wb_cyc_nxt   = 1'b1;
        tmo_nxt      = TMO_LOAD;
        state_nxt    = S_WR_WAIT;
      end

      S_WR_WAIT: begin
        if (r_wb_cyc && (wb_ack || wb_err)) begin
          wb_cyc_nxt = 1'b0;
          wb_we_nxt  = 1'b0;
          if (wb_err) begin
            err_cnt_nxt = w_cnt_inc;
            if (r_err_cnt == '0) first_err_nxt = r_wb_adr;
          end
          if (w_last) begin
            index_nxt = '0;
            state_nxt = S_RD_REQ;
          end else begin
            index_nxt = r_index + IDX_W'(1);
            state_nxt = S_WR_REQ;
          end
        end else if (r_tmo == '0) begin
          wb_cyc_nxt  = 1'b0;
          wb_we_nxt   = 1'b0;
          timeout_nxt = 1'b1;
          state_nxt   = S_DONE;
        end else begin
          tmo_nxt = r_tmo - TMO_W'(1);
        end
      end

      S_RD_REQ: begin
        wb_adr_nxt = w_req_adr;
        wb_we_nxt  = 1'b0;
        wb_cyc_nxt = 1'b1;
        tmo_nxt    = TMO_LOAD;
        state_nxt  = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // err wins over a simultaneous ack: the word is flagged bad.
        if (r_wb_cyc && (wb_ack || wb_err)) begin
          rd_err_nxt = wb_err;
          if (!wb_err) rd_data_nxt = wb_dat_r;
          wb_cyc_nxt = 1'b0;
          state_nxt  = S_COMPARE;
        end else if (r_tmo == '0) begin
          wb_cyc_nxt  = 1'b0;
          timeout_nxt = 1'b1;
          state_nxt   = S_DONE;
        end else begin
          tmo_nxt = r_tmo - TMO_W'(1);
        end
      end

      S_COMPARE: begin
        if (w_bad) begin
          err_cnt_nxt = w_cnt_inc;
          if (r_err_cnt == '0) first_err_nxt = r_wb_adr;
        end
        if (w_last) begin
          index_nxt = '0;
          if (!r_phase) begin
            phase_nxt = 1'b1;
            state_nxt = S_WR_REQ;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          index_nxt = r_index + IDX_W'(1);
          state_nxt = S_RD_REQ;
        end
      end

      S_DONE: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        pass_nxt  = w_pass;
        fail_nxt  = !w_pass;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_phase     <= 1'b0;
      r_index     <= '0;
      r_tmo       <= '0;
      r_rd_data   <= '0;
      r_rd_err    <= 1'b0;
      r_abort     <= 1'b0;
      r_wb_adr    <= '0;
      r_wb_dat_w  <= '0;
      r_wb_we     <= 1'b0;
      r_wb_cyc    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      r_phase     <= phase_nxt;
      r_index     <= index_nxt;
      r_tmo       <= tmo_nxt;
      r_rd_data   <= rd_data_nxt;
      r_rd_err    <= rd_err_nxt;
      r_abort     <= abort_nxt;
      r_wb_adr    <= wb_adr_nxt;
      r_wb_dat_w  <= wb_dat_w_nxt;
      r_wb_we     <= wb_we_nxt;
      r_wb_cyc    <= wb_cyc_nxt;
      r_busy      <= busy_nxt;
      r_done      <= done_nxt;
      r_pass      <= pass_nxt;
      r_fail      <= fail_nxt;
      r_timeout   <= timeout_nxt;
      r_err_cnt   <= err_cnt_nxt;
      r_first_err <= first_err_nxt;
    end
  end

  // cyc and stb share one register so they can never diverge.
  assign wb_adr         = r_wb_adr;
  assign wb_dat_w       = r_wb_dat_w;
  assign wb_sel         = {SEL_WIDTH{1'b1}};
  assign wb_cyc         = r_wb_cyc;
  assign wb_stb         = r_wb_cyc;
  assign wb_we          = r_wb_we;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail           = r_fail;
  assign timeout        = r_timeout;
  assign error_count    = r_err_cnt;
  assign first_err_addr = r_first_err;

endmodule

// File: tb/tb_dram_pattern_tester.sv
// Testbench for dram_pattern_tester: a Wishbone memory model with fault
// injection, plus a reference built from the sweep order and pattern formula.
module tb_dram_pattern_tester;

  localparam int unsigned AW   = 25;
  localparam int unsigned DW   = 128;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned NW   = 16;
  localparam int unsigned EW   = 4;
  localparam int unsigned BASE = 'h100;
  localparam logic [31:0] SEED = 32'h5EED_0000;
  localparam int          BUDGET = 3000;

  logic          clk = 1'b0;
  logic          user_rst;
  logic          start;
  logic          init_done;
  logic          init_error;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_w;
  logic [DW-1:0] wb_dat_r;
  logic [SW-1:0] wb_sel;
  logic          wb_cyc, wb_stb, wb_we;
  logic          wb_ack, wb_err;
  logic          busy, done, pass, fail, timeout;
  logic [EW-1:0] error_count;
  logic [AW-1:0] first_err_addr;

  dram_pattern_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .START_ADDR(BASE),
    .NUM_WORDS(NW), .SEED(SEED), .TIMEOUT_CYCLES(32), .ERR_CNT_WIDTH(EW)
  ) dut (
    .user_clk(clk), .user_rst(user_rst), .start(start),
    .init_done(init_done), .init_error(init_error),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .error_count(error_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } txn_t;

  // Model configuration, written only by the stimulus process.
  int  test_id;
  int  lat_max;
  bit  spurious_en;
  bit  zero_data;
  int  noack_adr;
  bit  flip_en [2][NW];
  int  flip_bit[2][NW];
  bit  err_en  [2][NW];
  bit  err_ack [2][NW];

  // Model state, written only by the slave process.
  txn_t          log_q[$];
  logic [DW-1:0] mem[NW];
  int            rd_cnt[NW];
  int            stb_cycles;
  int            proto_err;
  int            seen_id = -1;
  bit            active, responded;
  int            lat;
  logic [AW-1:0] p_adr;
  logic          p_we;
  logic [DW-1:0] p_dat;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [DW-1:0] pat(input int unsigned a, input bit inv);
    logic [DW-1:0] r;
    logic [31:0]   v;
    for (int i = 0; i < int'(DW / 32); i++) begin
      v = a ^ SEED ^ (32'(i) * 32'h0101_0101);
      r[32*i +: 32] = inv ? ~v : v;
    end
    return r;
  endfunction

  // Number of logged transactions that deviate from the full two-phase sweep order.
  function automatic int seq_errors();
    int  e;
    int  ph, r, w;
    bit  we;
    e = 0;
    for (int k = 0; k < log_q.size(); k++) begin
      ph = k / (2 * NW);
      r  = k % (2 * NW);
      we = (r < int'(NW));
      w  = r % NW;
      if (log_q[k].we !== we || log_q[k].adr !== AW'(BASE + w) ||
          (we && log_q[k].dat !== pat(BASE + w, ph[0])))
        e++;
    end
    return e;
  endfunction

  // Wishbone memory slave; drives responses at negedge for the following posedge.
  always @(negedge clk) begin
    int            w, ph;
    logic [DW-1:0] d;
    if (test_id != seen_id) begin
      seen_id = test_id;
      log_q.delete();
      for (int i = 0; i < int'(NW); i++) rd_cnt[i] = 0;
      stb_cycles = 0;
      proto_err  = 0;
      active     = 0;
      responded  = 0;
    end
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (wb_cyc === 1'b1 && wb_stb === 1'b1) begin
      stb_cycles++;
      if (wb_sel !== {SW{1'b1}}) proto_err++;
      if (active && (wb_adr !== p_adr || wb_we !== p_we || (p_we && wb_dat_w !== p_dat)))
        proto_err++;
      if (!active) begin
        active    = 1;
        responded = 0;
        lat       = $urandom_range(lat_max, 0);
        p_adr     = wb_adr;
        p_we      = wb_we;
        p_dat     = wb_dat_w;
      end
      w = int'(wb_adr) - int'(BASE);
      if (w < 0 || w >= int'(NW)) begin
        proto_err++;
        w = 0;
      end
      if (responded) begin
        proto_err++;
      end else if (int'(wb_adr) == noack_adr) begin
        // hold the transaction forever
      end else if (lat > 0) begin
        lat--;
      end else begin
        responded = 1;
        if (wb_we) begin
          mem[w] = wb_dat_w;
          wb_ack = 1'b1;
          log_q.push_back('{1'b1, wb_adr, wb_dat_w});
        end else begin
          ph = (rd_cnt[w] > 0) ? 1 : 0;
          rd_cnt[w]++;
          d = zero_data ? '0 : mem[w];
          if (flip_en[ph][w]) d[flip_bit[ph][w]] = ~d[flip_bit[ph][w]];
          if (err_en[ph][w]) begin
            wb_err = 1'b1;
            wb_ack = err_ack[ph][w];
          end else begin
            wb_ack = 1'b1;
          end
          wb_dat_r = d;
          log_q.push_back('{1'b0, wb_adr, d});
        end
      end
    end else begin
      active = 0;
      if (wb_cyc !== wb_stb) proto_err++;
      if (spurious_en && $urandom_range(3, 0) == 0) wb_ack = 1'b1;
    end
  end

  task automatic clear_cfg();
    lat_max     = 0;
    spurious_en = 0;
    zero_data   = 0;
    noack_adr   = -1;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < int'(NW); i++) begin
        flip_en[p][i]  = 0;
        flip_bit[p][i] = 0;
        err_en[p][i]   = 0;
        err_ack[p][i]  = 0;
      end
  endtask

  task automatic new_test();
    test_id++;
    clear_cfg();
    @(negedge clk);
  endtask

  // Pulse start, then wait (bounded) for done.
  task automatic kick(output bit ok);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int c = 0; c < BUDGET; c++) begin
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we, busy, done, pass, fail, timeout} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {wb_cyc, wb_stb, wb_we, busy, done, pass, fail, timeout});
    end
    n_cmp++;
    if (wb_adr !== '0 || wb_dat_w !== '0 || error_count !== '0 || first_err_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_regs: adr=%0h dat=%0h cnt=%0d first=%0h expected all 0",
               wb_adr, wb_dat_w, error_count, first_err_addr);
    end
    n_cmp++;
    if (wb_sel !== {SW{1'b1}}) begin
      n_bad++;
      $display("FAIL reset_sel: got %0h expected all ones", wb_sel);
    end
    user_rst  = 1'b0;
    init_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ideal();
    bit ok;
    new_test();
    kick(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ideal_done: got no done expected done within %0d", BUDGET); end
    n_cmp++;
    if (log_q.size() !== 4 * NW) begin
      n_bad++; $display("FAIL ideal_ntxn: got %0d expected %0d", log_q.size(), 4 * NW);
    end
    n_cmp++;
    if (seq_errors() !== 0) begin n_bad++; $display("FAIL ideal_seq: got %0d bad txns expected 0", seq_errors()); end
    n_cmp++;
    if (proto_err !== 0) begin n_bad++; $display("FAIL ideal_proto: got %0d violations expected 0", proto_err); end
    n_cmp++;
    if ({busy, done, pass, fail, timeout} !== 5'b01100 || error_count !== '0) begin
      n_bad++;
      $display("FAIL ideal_status: got bdpft=%b cnt=%0d expected 01100 cnt=0",
               {busy, done, pass, fail, timeout}, error_count);
    end
  endtask

  task automatic test_bitflip();
    bit ok;
    new_test();
    flip_en[0][5]  = 1;
    flip_bit[0][5] = 0;
    kick(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL flip_done: got no done expected done"); end
    n_cmp++;
    if (error_count !== EW'(1) || first_err_addr !== AW'('h105)) begin
      n_bad++;
      $display("FAIL flip_err: got cnt=%0d first=%0h expected cnt=1 first=105", error_count, first_err_addr);
    end
    n_cmp++;
    if ({pass, fail, timeout} !== 3'b010) begin
      n_bad++; $display("FAIL flip_pf: got pft=%b expected 010", {pass, fail, timeout});
    end
  endtask

  task automatic test_err_reads();
    bit ok;
    new_test();
    err_en[0][7]   = 1;
    err_en[1][7]   = 1;
    err_ack[1][7]  = 1;
    flip_en[1][2]  = 1;
    flip_bit[1][2] = 77;
    kick(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL errrd_done: got no done expected done"); end
    n_cmp++;
    if (error_count !== EW'(3) || first_err_addr !== AW'('h107)) begin
      n_bad++;
      $display("FAIL errrd_err: got cnt=%0d first=%0h expected cnt=3 first=107", error_count, first_err_addr);
    end
    n_cmp++;
    if ({pass, fail} !== 2'b01 || log_q.size() !== 4 * NW) begin
      n_bad++; $display("FAIL errrd_pf: got pf=%b ntxn=%0d expected 01 ntxn=64", {pass, fail}, log_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    int snap;
    new_test();
    noack_adr = 'h103;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int c = 0; c < BUDGET; c++) begin
      if (wb_stb === 1'b1 && wb_adr === AW'('h103)) begin ok = 1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tmo_reach: got no stb to 103 expected one"); end
    cnt = 0;
    while (wb_stb === 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt !== 32) begin n_bad++; $display("FAIL tmo_len: got stb for %0d cycles expected 32", cnt); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, pass, fail, timeout} !== 5'b01011) begin
      n_bad++; $display("FAIL tmo_status: got bdpft=%b expected 01011", {busy, done, pass, fail, timeout});
    end
    snap = stb_cycles;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (stb_cycles !== snap || log_q.size() !== 3) begin
      n_bad++;
      $display("FAIL tmo_quiet: got stb_cycles %0d->%0d ntxn=%0d expected unchanged ntxn=3",
               snap, stb_cycles, log_q.size());
    end
  endtask

  task automatic test_gating();
    bit ok;
    new_test();
    init_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || stb_cycles !== 0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL gate_nodone: got busy=%b stb_cycles=%0d done=%b expected 0 0 1 (held)",
               busy, stb_cycles, done);
    end
    new_test();
    init_done  = 1'b1;
    init_error = 1'b1;
    kick(ok);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (!ok || {busy, done, pass, fail, timeout} !== 5'b01010 || stb_cycles !== 0) begin
      n_bad++;
      $display("FAIL gate_initerr: got ok=%b bdpft=%b stb_cycles=%0d expected 1 01010 0",
               ok, {busy, done, pass, fail, timeout}, stb_cycles);
    end
    init_error = 1'b0;
  endtask

  task automatic test_busy_restart();
    bit ok;
    new_test();
    lat_max = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got busy=%b expected 1", busy); end
    kick(ok);
    n_cmp++;
    if (!ok || log_q.size() !== 4 * NW || seq_errors() !== 0 || pass !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_ignored: got ok=%b ntxn=%0d seqerr=%0d pass=%b expected 1 64 0 1",
               ok, log_q.size(), seq_errors(), pass);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    new_test();
    noack_adr = 'h100;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      if (wb_stb === 1'b1 && wb_we === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || wb_stb !== 1'b1) begin n_bad++; $display("FAIL rstmid_wait: got stb=%b expected 1 in write wait", wb_stb); end
    user_rst = 1'b1;
    @(negedge clk);
    user_rst = 1'b0;
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we, busy, done, pass, fail, timeout} !== 8'b0 ||
        wb_adr !== '0 || wb_dat_w !== '0 || error_count !== '0 || first_err_addr !== '0) begin
      n_bad++;
      $display("FAIL rstmid_vals: got flags=%b adr=%0h cnt=%0d expected all reset values",
               {wb_cyc, wb_stb, wb_we, busy, done, pass, fail, timeout}, wb_adr, error_count);
    end
    noack_adr = -1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (wb_stb !== 1'b0 || busy !== 1'b0 || log_q.size() !== 0) begin
      n_bad++;
      $display("FAIL rstmid_quiet: got stb=%b busy=%b ntxn=%0d expected 0 0 0", wb_stb, busy, log_q.size());
    end
  endtask

  task automatic test_saturate();
    bit ok;
    new_test();
    zero_data = 1;
    kick(ok);
    n_cmp++;
    if (!ok || error_count !== EW'(15) || first_err_addr !== AW'(BASE) || fail !== 1'b1 || pass !== 1'b0) begin
      n_bad++;
      $display("FAIL sat: got ok=%b cnt=%0d first=%0h fail=%b pass=%b expected 1 15 100 1 0",
               ok, error_count, first_err_addr, fail, pass);
    end
  endtask

  task automatic test_random(input int iter);
    bit ok;
    int n_faults;
    int kind;
    int exp_first;
    int exp_cnt;
    new_test();
    lat_max     = 3;
    spurious_en = 1;
    n_faults    = 0;
    exp_first   = 0;
    for (int p = 0; p < 2; p++)
      for (int w = 0; w < int'(NW); w++) begin
        kind = $urandom_range(9, 0);
        if (kind <= 2) begin
          if (kind == 0) begin
            flip_en[p][w]  = 1;
            flip_bit[p][w] = $urandom_range(DW - 1, 0);
          end else begin
            err_en[p][w]  = 1;
            err_ack[p][w] = (kind == 2);
          end
          if (n_faults == 0) exp_first = BASE + w;
          n_faults++;
        end
      end
    exp_cnt = (n_faults > 15) ? 15 : n_faults;
    kick(ok);
    n_cmp++;
    if (!ok || log_q.size() !== 4 * NW || seq_errors() !== 0 || proto_err !== 0) begin
      n_bad++;
      $display("FAIL rand%0d_bus: got ok=%b ntxn=%0d seqerr=%0d proto=%0d expected 1 64 0 0",
               iter, ok, log_q.size(), seq_errors(), proto_err);
    end
    n_cmp++;
    if (error_count !== EW'(exp_cnt) || first_err_addr !== AW'(exp_first)) begin
      n_bad++;
      $display("FAIL rand%0d_err: got cnt=%0d first=%0h expected cnt=%0d first=%0h",
               iter, error_count, first_err_addr, exp_cnt, exp_first);
    end
    n_cmp++;
    if ({busy, done, pass, fail, timeout} !== {2'b01, n_faults == 0, n_faults != 0, 1'b0}) begin
      n_bad++;
      $display("FAIL rand%0d_status: got bdpft=%b expected pass=%0d", iter,
               {busy, done, pass, fail, timeout}, n_faults == 0);
    end
  endtask

  initial begin
    start      = 1'b0;
    init_done  = 1'b0;
    init_error = 1'b0;
    user_rst   = 1'b1;
    test_id    = 0;
    clear_cfg();
    test_reset();
    test_ideal();
    test_bitflip();
    test_err_reads();
    test_timeout();
    test_gating();
    test_busy_restart();
    test_reset_mid();
    test_saturate();
    for (int i = 0; i < 6; i++) test_random(i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_pattern_tester.md
Name: dram_pattern_tester

Overview:
Wishbone master that sits directly upstream of the litedram_core user_port_wishbone_0 port. It sweeps a configurable DRAM address range in two phases: write an address-derived pattern and read it back, then repeat with the inverted pattern. It counts mismatches and reports pass/fail. It replaces the single-word write/read check in the board top and drives the LEDs from its status outputs.

Parameters:
ADDR_WIDTH, 25, wishbone word-address width; must be ≤ 32.
DATA_WIDTH, 256, wishbone data width; a multiple of 32.
SEL_WIDTH, DATA_WIDTH/8, byte-select width.
START_ADDR, 0, first word address of the sweep.
NUM_WORDS, 1024, words per sweep; ≥ 1, and START_ADDR+NUM_WORDS ≤ 2^ADDR_WIDTH.
SEED, 32'h5EED_0000, XOR seed for the pattern.
TIMEOUT_CYCLES, 4096, maximum cycles to wait for ack or err per transaction.
ERR_CNT_WIDTH, 16, width of the error counter.

Ports:
user_clk  in  1  sole clock (litedram user clock)
user_rst  in  1  synchronous, active-high reset
start  in  1  begin a test; sampled in IDLE only
init_done  in  1  litedram calibration complete
init_error  in  1  litedram calibration failed
wb_adr  out  ADDR_WIDTH  word address
wb_dat_w  out  DATA_WIDTH  write data
wb_dat_r  in  DATA_WIDTH  read data
wb_sel  out  SEL_WIDTH  byte selects; always all ones
wb_cyc  out  1  bus cycle
wb_stb  out  1  strobe
wb_we  out  1  write enable
wb_ack  in  1  transfer acknowledge
wb_err  in  1  transfer error
busy  out  1  test in progress
done  out  1  test finished; held until the next accepted start
pass  out  1  done, error_count==0 and no timeout
fail  out  1  done and not pass
timeout  out  1  a transaction exceeded TIMEOUT_CYCLES
error_count  out  ERR_CNT_WIDTH  saturating mismatch/err count
first_err_addr  out  ADDR_WIDTH  address of the first failing word

Behaviour:
- Reset values:
  - wb_cyc, wb_stb, wb_we, busy, done, pass, fail, timeout = 0.
  - wb_adr, wb_dat_w, error_count, first_err_addr = 0.
  - wb_sel = all ones.
  - State = IDLE.
- Reset asserted mid-transaction: cyc/stb are low after the reset edge, and any in-flight ack is ignored.
- Pattern:
  - a = wb_adr zero-extended to 32 bits.
  - Lane i (bits 32i+31:32i, i = 0..DATA_WIDTH/32-1): P(a) = a ^ SEED ^ (i * 32'h01010101), truncated to 32 bits.
  - Phase 0 uses P(a); phase 1 uses ~P(a).
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, COMPARE, DONE.
- IDLE:
  - On start=1: clear done/pass/fail/timeout/error_count/first_err_addr, set busy, set phase=0, set index=0.
  - If init_done=1 and init_error=0, go to WR_REQ.
  - If init_error=1, go to DONE, which yields fail=1.
  - Otherwise (init_done=0), ignore start.
- WR_REQ: register wb_adr=START_ADDR+index, wb_dat_w=pattern, wb_we=1, cyc=stb=1, and load the timeout counter. Go to WR_WAIT.
- WR_WAIT:
  - On ack or err: drop cyc/stb/we on the next edge. err increments error_count.
  - Last word (index==NUM_WORDS-1) → index=0, go to RD_REQ. Otherwise index+1, go to WR_REQ.
- RD_REQ: same as WR_REQ with wb_we=0; wb_dat_w is don't-care. Go to RD_WAIT.
- RD_WAIT: on ack, capture wb_dat_r into a register; on err, flag the word bad. Drop cyc/stb and go to COMPARE.
- COMPARE:
  - Mismatch against the phase pattern, or err, increments error_count (saturates at all ones).
  - On the first error only, latch first_err_addr=wb_adr.
  - Last word of phase 0 → phase=1, index=0, go to WR_REQ. Last word of phase 1 → DONE. Otherwise index+1, go to RD_REQ.
- Bus signal stability:
  - At most one outstanding transaction.
  - adr/dat_w/we/sel stay stable while stb=1.
  - cyc and stb always change together.
  - ack/err are honoured only while stb=1; spurious ack in any other state is ignored.
- Timeout:
  - The counter decrements each cycle in a *_WAIT state.
  - Reaching 0 without ack/err: drop cyc/stb, set timeout=1, go to DONE.
- DONE: busy=0, done=1, pass/fail per definition. These hold until reset or an accepted start in IDLE; DONE returns to IDLE in the same cycle as the flags are set. A start while busy is ignored.
- Simultaneous ack and err: treat as err.
- Total transactions per test without timeout: 4*NUM_WORDS.

Test Plan:
1. Ideal zero-wait memory model, NUM_WORDS=16, START_ADDR=0x100, start pulse after init_done → exactly 64 transactions (32 writes, 32 reads). Addresses 0x100..0x10F, each twice per phase. done=1, pass=1, error_count=0.
2. Model flips dat_r bit 0 on the phase-0 read of word 5 → error_count=1, first_err_addr=0x105, fail=1, pass=0.
3. Model returns err on the read of word 7 in both phases, plus a data mismatch on word 2 in phase 1 → error_count=3, first_err_addr=0x107.
4. Model never acks address 0x103, TIMEOUT_CYCLES=32 → cyc/stb low 32 cycles after stb rose. timeout=1, fail=1, done=1, and no further transactions.
5. Gating and reset:
   - start with init_done=0 → no bus activity, busy=0.
   - start with init_error=1 → done=1, fail=1, zero transactions.
   - Second start while busy → ignored.
   - user_rst asserted mid-WR_WAIT → all outputs at reset values next cycle.
6. ERR_CNT_WIDTH=4, NUM_WORDS=16, model returns all-zero read data → error_count saturates at 15, first_err_addr=START_ADDR, fail=1.
